// File: rtl/msg_frame_tx.sv
// Status-message framer: queues compact event descriptors and streams each one as a fixed
// ASCII frame over a valid/ready byte interface with a minimum inter-byte gap.
module msg_frame_tx #(
  parameter int unsigned CLKS_PER_BYTE = 4340,
  parameter int unsigned QUEUE_DEPTH   = 4
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic [1:0] evt_type,
  input  logic [1:0] evt_unit,
  input  logic [1:0] evt_su,
  input  logic [1:0] evt_blk,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = $clog2(CLKS_PER_BYTE);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  function automatic logic [7:0] unit_char(input logic [1:0] u);
    case (u)
      2'd0:    return "E";
      2'd1:    return "C";
      2'd2:    return "R";
      default: return "?";
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] t);
    case (t)
      2'd0:    return 4'd9;
      2'd1:    return 4'd11;
      2'd2:    return 4'd12;
      default: return 4'd4;
    endcase
  endfunction

  // Entry layout: {type[7:6], unit[5:4], su[3:2], blk[1:0]}
  function automatic logic [7:0] frame_byte(input logic [7:0] e, input logic [3:0] i);
    logic [7:0] u, n, b;
    u = unit_char(e[5:4]);
    n = 8'h31 + {6'd0, e[3:2]};
    b = 8'h31 + {6'd0, e[1:0]};
    case (e[7:6])
      2'd0: begin
        case (i)
          4'd0: return "F";
          4'd1: return "I";
          4'd2: return "M";
          4'd3: return "-";
          4'd4: return u;
          4'd5: return "S";
          4'd6: return "U";
          4'd7: return n;
          4'd8: return "-";
          default: return "#";
        endcase
      end
      2'd1: begin
        case (i)
          4'd0: return "B";
          4'd1: return "P";
          4'd2: return "M";
          4'd3: return "-";
          4'd4: return "S";
          4'd5: return "U";
          4'd6: return n;
          4'd7: return "-";
          4'd8: return "B";
          4'd9: return b;
          4'd10: return "-";
          default: return "#";
        endcase
      end
      2'd2: begin
        case (i)
          4'd0: return "B";
          4'd1: return "D";
          4'd2: return "M";
          4'd3: return "-";
          4'd4: return u;
          4'd5: return "S";
          4'd6: return "U";
          4'd7: return n;
          4'd8: return "-";
          4'd9: return "B";
          4'd10: return b;
          4'd11: return "-";
          default: return "#";
        endcase
      end
      default: begin
        case (i)
          4'd0: return "E";
          4'd1: return "N";
          4'd2: return "D";
          4'd3: return "-";
          default: return "#";
        endcase
      end
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [7:0]        mem_q [QUEUE_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        frame_q, frame_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop;
  logic [7:0]        head;

  assign full      = (count_q == CntW'(QUEUE_DEPTH));
  assign empty     = (count_q == '0);
  assign evt_ready = !rst && !full && !done_q;
  assign push      = evt_valid && evt_ready;
  assign head      = mem_q[rd_ptr_q];

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == StSend) || !empty;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = done_q;
    pop        = 1'b0;
    gap_d      = (gap_q != '0) ? gap_q - GapW'(1) : '0;
    // Drops while done are silent; only a full queue counts as overflow.
    overflow_d = overflow_q | (evt_valid && full && !done_q);

    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_d = head;
          idx_d   = 4'd0;
          state_d = StSend;
          if (gap_d == '0) begin
            tx_valid_d = 1'b1;
            tx_data_d  = frame_byte(head, 4'd0);
          end
        end
      end
      StSend: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          gap_d      = GapW'(CLKS_PER_BYTE - 1);
          idx_d      = idx_q + 4'd1;
          if (idx_q == last_idx(frame_q[7:6])) begin
            if (frame_q[7:6] == 2'd3) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (!tx_valid_q && gap_d == '0) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(frame_q, idx_q);
        end
      end
      default: ;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (push) mem_q[wr_ptr_q] <= {evt_type, evt_unit, evt_su, evt_blk};
  end

endmodule

// File: tb/tb_msg_frame_tx.sv
// Directed bench for msg_frame_tx: frame contents, byte spacing, queue overflow, END latch
// and mid-frame reset.
module tb_msg_frame_tx;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       evt_valid = 1'b0;
  logic       evt_ready;
  logic [1:0] evt_type = '0, evt_unit = '0, evt_su = '0, evt_blk = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy, done, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int push_cyc = 0;
  logic [7:0] acc_data[$];
  int         acc_cyc[$];

  msg_frame_tx #(.CLKS_PER_BYTE(4), .QUEUE_DEPTH(4)) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_type (evt_type),
    .evt_unit (evt_unit),
    .evt_su   (evt_su),
    .evt_blk  (evt_blk),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk_50M = ~clk_50M;

  // Records every accepted byte with the cycle number of the accepting edge.
  always @(posedge clk_50M) begin
    cyc++;
    if (tx_valid && tx_ready) begin
      acc_data.push_back(tx_data);
      acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic push_evt(input logic [1:0] t, input logic [1:0] u, input logic [1:0] s,
                          input logic [1:0] b);
    evt_valid = 1'b1;
    evt_type  = t;
    evt_unit  = u;
    evt_su    = s;
    evt_blk   = b;
    @(posedge clk_50M);
    #1;
    evt_valid = 1'b0;
    push_cyc  = cyc;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (acc_data.size() < n && k < budget) begin
      @(posedge clk_50M);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    acc_data.delete();
    acc_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data);
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b done=%b ovf=%b, required all 0",
               tx_valid, busy, done, overflow);
    end
    checks++;
    if (evt_ready !== 1'b0) begin
      errors++; $display("FAIL reset_evt_ready: got %b, required 0 during rst", evt_ready);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (evt_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b, required 1", evt_ready);
    end
    acc_data.delete();
    acc_cyc.delete();
  endtask

  task automatic test_fim_single();
    string s = "FIM-CSU3-#";
    logic [7:0] got;
    tx_ready = 1'b1;
    push_evt(2'd0, 2'd1, 2'd2, 2'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL fim_busy_after_push: got %b, required 1", busy);
    end
    wait_bytes(10, 200);
    checks++;
    if (acc_data.size() != 10) begin
      errors++; $display("FAIL fim_count: got %0d bytes, required 10", acc_data.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fim_busy_after_hash: got %b, required 0", busy);
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (i < acc_data.size()) ? acc_data[i] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL fim_byte%0d: got %h, required %h", i, got, s[i]);
      end
    end
    checks++;
    if (acc_cyc.size() < 1 || acc_cyc[0] - push_cyc != 2) begin
      errors++;
      $display("FAIL fim_first_latency: got %0d, required 2",
               acc_cyc.size() > 0 ? acc_cyc[0] - push_cyc : -1);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
        errors++;
        $display("FAIL fim_gap%0d: got %0d cycles, required 4", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    step(6);
    acc_data.delete();
    acc_cyc.delete();
  endtask

  task automatic test_back_to_back();
    string s = "BDM-ESU1-B4-#BPM-SU2-B1-#";
    logic [7:0] got;
    tx_ready = 1'b1;
    push_evt(2'd2, 2'd0, 2'd0, 2'd3);
    push_evt(2'd1, 2'd0, 2'd1, 2'd0);
    wait_bytes(25, 300);
    checks++;
    if (acc_data.size() != 25) begin
      errors++; $display("FAIL b2b_count: got %0d bytes, required 25", acc_data.size());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (i < acc_data.size()) ? acc_data[i] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h, required %h", i, got, s[i]);
      end
    end
    checks++;
    if (acc_cyc.size() < 14 || acc_cyc[13] - acc_cyc[12] != 4) begin
      errors++;
      $display("FAIL b2b_frame_gap: got %0d cycles, required 4",
               acc_cyc.size() >= 14 ? acc_cyc[13] - acc_cyc[12] : -1);
    end
    step(6);
    acc_data.delete();
    acc_cyc.delete();
  endtask

  task automatic test_overflow();
    string s = "FIM-RSU1-#BPM-SU4-B3-#BDM-CSU2-B2-#FIM-ESU4-#BPM-SU1-B4-#";
    logic [7:0] got;
    tx_ready = 1'b0;
    push_evt(2'd0, 2'd2, 2'd0, 2'd0);
    push_evt(2'd1, 2'd0, 2'd3, 2'd2);
    push_evt(2'd2, 2'd1, 2'd1, 2'd1);
    push_evt(2'd0, 2'd0, 2'd3, 2'd0);
    push_evt(2'd1, 2'd0, 2'd0, 2'd3);
    checks++;
    if (evt_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got ready=%b ovf=%b, required ready=0 ovf=0", evt_ready, overflow);
    end
    push_evt(2'd0, 2'd1, 2'd1, 2'd0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b, required 1", overflow);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h46) begin
      errors++;
      $display("FAIL ovf_stall_a: got valid=%b data=%h, required 1/46", tx_valid, tx_data);
    end
    step(7);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h46) begin
      errors++;
      $display("FAIL ovf_stall_b: got valid=%b data=%h, required 1/46", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_bytes(57, 400);
    step(20);
    checks++;
    if (acc_data.size() != 57) begin
      errors++; $display("FAIL ovf_count: got %0d bytes, required 57", acc_data.size());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (i < acc_data.size()) ? acc_data[i] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL ovf_byte%0d: got %h, required %h", i, got, s[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end: got busy=%b ovf=%b, required busy=0 ovf=1", busy, overflow);
    end
  endtask

  task automatic test_end_done();
    string s = "FIM-ESU1-#END-#";
    logic [7:0] got;
    do_reset();
    tx_ready = 1'b1;
    push_evt(2'd0, 2'd0, 2'd0, 2'd0);
    push_evt(2'd3, 2'd0, 2'd0, 2'd0);
    wait_bytes(14, 200);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL end_done_early: got %b, required 0", done);
    end
    wait_bytes(15, 50);
    checks++;
    if (done !== 1'b1 || evt_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL end_done: got done=%b ready=%b busy=%b, required 1/0/0",
               done, evt_ready, busy);
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (i < acc_data.size()) ? acc_data[i] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL end_byte%0d: got %h, required %h", i, got, s[i]);
      end
    end
    push_evt(2'd0, 2'd1, 2'd1, 2'd0);
    step(20);
    checks++;
    if (acc_data.size() != 15 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL end_frozen: got %0d bytes valid=%b, required 15/0",
               acc_data.size(), tx_valid);
    end
    checks++;
    if (overflow !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL end_sticky: got ovf=%b done=%b, required 0/1", overflow, done);
    end
  endtask

  task automatic test_reset_midframe();
    string s = "BDM-?SU1-#";
    logic [7:0] got;
    do_reset();
    tx_ready = 1'b1;
    push_evt(2'd2, 2'd1, 2'd2, 2'd0);
    push_evt(2'd0, 2'd2, 2'd2, 2'd0);
    wait_bytes(3, 100);
    rst = 1'b1;
    step(1);
    checks++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got data=%h valid=%b busy=%b done=%b ovf=%b, required 0",
               tx_data, tx_valid, busy, done, overflow);
    end
    rst = 1'b0;
    step(10);
    checks++;
    if (acc_data.size() != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_queue: got %0d bytes busy=%b, required 3/0", acc_data.size(), busy);
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < acc_data.size()) ? acc_data[i] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL rstmid_prefix%0d: got %h, required %h", i, got, s[i]);
      end
    end
    s = "FIM-?SU1-#";
    push_evt(2'd0, 2'd3, 2'd0, 2'd0);
    wait_bytes(13, 200);
    for (int i = 0; i < s.len(); i++) begin
      got = (i + 3 < acc_data.size()) ? acc_data[i+3] : 8'h00;
      checks++;
      if (got !== s[i]) begin
        errors++; $display("FAIL rstmid_fim%0d: got %h, required %h", i, got, s[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fim_single();
    test_back_to_back();
    test_overflow();
    test_end_done();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
